a2bus_event_fifo: RTL and testbench

Downstream consumer of the Apple II bus interface stage. On every `data_in_strobe` pulse it filters the latched bus cycle (address, data, rw_n) against a programmable address window. It stamps each matching cycle with an 8-bit sequence number and queues it in a first-word-fall-through FIFO. Soft-switch decoders and the ESP/host bridge drain the FIFO through a valid/ready handshake. Overflow is counted rather than stalling the bus side, because the bus side cannot be stalled.

---
 rtl/a2bus_event_fifo.sv | 159 +++++++++++++++
 tb/tb_a2bus_event_fifo.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a2bus_event_fifo.sv
// Apple II bus event capture FIFO.
// Filters strobed bus cycles against an address window, stamps each hit with a
// sequence number and queues it in a first-word-fall-through FIFO. The bus side
// can never be stalled, so overflow drops the event and counts it instead.
module a2bus_event_fifo #(
  parameter int unsigned DEPTH       = 16,
  parameter logic [15:0] ADDR_LO     = 16'hC000,
  parameter logic [15:0] ADDR_HI     = 16'hC0FF,
  parameter bit          WRITES_ONLY = 1'b0
) (
  input  logic                     clk_logic,
  input  logic                     device_reset,
  input  logic [15:0]              addr_i,
  input  logic [7:0]               data_i,
  input  logic                     rw_n_i,
  input  logic                     data_in_strobe_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  output logic                     evt_valid_o,
  input  logic                     evt_ready_i,
  output logic [15:0]              evt_addr_o,
  output logic [7:0]               evt_data_o,
  output logic                     evt_rw_n_o,
  output logic [7:0]               evt_seq_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [7:0]               drop_count_o,
  output logic                     overflow_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef struct packed {
    logic        rw_n;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  seq;
  } entry_t;

  // Stage 1 capture register and sequence counter
  logic        s1_valid_d, s1_valid_q;
  entry_t      s1_entry_d, s1_entry_q;
  logic [7:0]  seq_d, seq_q;

  // FIFO bookkeeping
  logic [PtrW-1:0] wr_ptr_d, wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_d, rd_ptr_q;
  logic [CntW-1:0] count_d, count_q;
  logic [7:0]      drop_d, drop_q;
  logic            ovf_d, ovf_q;

  entry_t mem_q [DEPTH];
  entry_t head;

  logic in_window;
  logic hit;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Window filter; both bounds are inclusive and unsigned.
  assign in_window = (addr_i >= ADDR_LO) && (addr_i <= ADDR_HI);
  assign hit       = data_in_strobe_i && enable_i && in_window && (!WRITES_ONLY || !rw_n_i);

  assign full = (count_q == CntW'(DEPTH));
  assign pop  = evt_valid_o && evt_ready_i;
  // A full FIFO still accepts the stage-1 entry when the head leaves in the same cycle.
  assign push = s1_valid_q && (!full || pop);
  assign drop = s1_valid_q && !push;

  // Next-state for capture stage, pointers, occupancy and drop accounting.
  always_comb begin
    s1_valid_d = hit;
    s1_entry_d = s1_entry_q;
    seq_d      = seq_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    drop_d     = drop_q;
    ovf_d      = ovf_q;

    if (hit) begin
      s1_entry_d = '{rw_n: rw_n_i, addr: addr_i, data: data_i, seq: seq_q};
      // Every hit consumes a number, even if it is dropped later, so losses show as gaps.
      seq_d      = seq_q + 8'd1;
    end

    if (clear_i) begin
      // Flush discards this cycle's hit, push and pop; the sequence keeps its value.
      s1_valid_d = 1'b0;
      s1_entry_d = s1_entry_q;
      seq_d      = seq_q;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      drop_d     = '0;
      ovf_d      = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
      if (drop) begin
        drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
        ovf_d  = 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_logic) begin
    if (device_reset) begin
      s1_valid_q <= 1'b0;
      s1_entry_q <= '0;
      seq_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_q     <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_entry_q <= s1_entry_d;
      seq_q      <= seq_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_q     <= drop_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage array; contents are not reset, validity is carried by the counter.
  always_ff @(posedge clk_logic) begin
    if (!device_reset && !clear_i && push) begin
      mem_q[wr_ptr_q] <= s1_entry_q;
    end
  end

  // First-word-fall-through head.
  assign head         = mem_q[rd_ptr_q];
  assign evt_valid_o  = (count_q != '0);
  assign evt_addr_o   = head.addr;
  assign evt_data_o   = head.data;
  assign evt_rw_n_o   = head.rw_n;
  assign evt_seq_o    = head.seq;
  assign count_o      = count_q;
  assign drop_count_o = drop_q;
  assign overflow_o   = ovf_q;

endmodule

// File: tb/tb_a2bus_event_fifo.sv
// Bench for a2bus_event_fifo: queue-level reference model, scoreboard monitor,
// directed scenarios followed by randomized traffic.
module tb_a2bus_event_fifo;

  localparam int unsigned Depth = 16;

  typedef struct packed {
    logic        rw_n;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [7:0]  seq;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        strobe = 1'b0;
  logic        en = 1'b1;
  logic        clr = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] addr = '0;
  logic [7:0]  data = '0;
  logic        rw_n = 1'b1;

  logic        evt_valid, evt_rw_n;
  logic [15:0] evt_addr;
  logic [7:0]  evt_data, evt_seq, drop_count;
  logic [4:0]  count;
  logic        overflow;

  logic        wo_valid, wo_rw_n;
  logic [15:0] wo_addr;
  logic [7:0]  wo_data, wo_seq, wo_drop_count;
  logic [4:0]  wo_count;
  logic        wo_overflow;

  a2bus_event_fifo #(.DEPTH(Depth)) u_dut (
    .clk_logic(clk), .device_reset(rst), .addr_i(addr), .data_i(data), .rw_n_i(rw_n),
    .data_in_strobe_i(strobe), .enable_i(en), .clear_i(clr),
    .evt_valid_o(evt_valid), .evt_ready_i(ready), .evt_addr_o(evt_addr),
    .evt_data_o(evt_data), .evt_rw_n_o(evt_rw_n), .evt_seq_o(evt_seq),
    .count_o(count), .drop_count_o(drop_count), .overflow_o(overflow)
  );

  // Writes-only variant, never drained.
  a2bus_event_fifo #(.DEPTH(Depth), .WRITES_ONLY(1'b1)) u_wo (
    .clk_logic(clk), .device_reset(rst), .addr_i(addr), .data_i(data), .rw_n_i(rw_n),
    .data_in_strobe_i(strobe), .enable_i(en), .clear_i(clr),
    .evt_valid_o(wo_valid), .evt_ready_i(1'b0), .evt_addr_o(wo_addr),
    .evt_data_o(wo_data), .evt_rw_n_o(wo_rw_n), .evt_seq_o(wo_seq),
    .count_o(wo_count), .drop_count_o(wo_drop_count), .overflow_o(wo_overflow)
  );

  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;

  // Reference model state
  ev_t        mdl_q[$];
  ev_t        exp_q[$];
  logic       m_s1v;
  ev_t        m_s1;
  logic [7:0] m_seq, m_drop;
  logic       m_ovf;
  logic       w_s1v;
  int         w_cnt;
  logic [7:0] w_drop;
  logic       w_ovf;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit in_win(input logic [15:0] a);
    return (a >= 16'hC000) && (a <= 16'hC0FF);
  endfunction

  // Behavioural model: one pending capture, then a bounded queue.
  always @(posedge clk) begin
    bit hit, whit, pop;
    hit  = strobe && en && in_win(addr);
    whit = hit && !rw_n;
    if (rst) begin
      mdl_q.delete(); exp_q.delete();
      m_s1v = 0; m_seq = 0; m_drop = 0; m_ovf = 0;
      w_s1v = 0; w_cnt = 0; w_drop = 0; w_ovf = 0;
    end else if (clr) begin
      mdl_q.delete(); exp_q.delete();
      m_s1v = 0; m_drop = 0; m_ovf = 0;
      w_s1v = 0; w_cnt = 0; w_drop = 0; w_ovf = 0;
    end else begin
      pop = (mdl_q.size() != 0) && ready;
      if (pop) void'(mdl_q.pop_front());
      if (m_s1v) begin
        if (mdl_q.size() < Depth) begin
          mdl_q.push_back(m_s1);
          exp_q.push_back(m_s1);
        end else begin
          if (m_drop != 8'hFF) m_drop++;
          m_ovf = 1;
        end
      end
      m_s1v = hit;
      if (hit) begin
        m_s1 = {rw_n, addr, data, m_seq};
        m_seq++;
      end
      if (w_s1v) begin
        if (w_cnt < Depth) w_cnt++;
        else begin
          if (w_drop != 8'hFF) w_drop++;
          w_ovf = 1;
        end
      end
      w_s1v = whit;
    end
  end

  // Monitor: compare status every cycle and the head against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      check("count", 64'(count), 64'(mdl_q.size()));
      check("valid", 64'(evt_valid), 64'(mdl_q.size() != 0));
      check("drop_count", 64'(drop_count), 64'(m_drop));
      check("overflow", 64'(overflow), 64'(m_ovf));
      check("wo_count", 64'(wo_count), 64'(w_cnt));
      check("wo_drop", 64'(wo_drop_count), 64'(w_drop));
      check("wo_overflow", 64'(wo_overflow), 64'(w_ovf));
      if (evt_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL head: got valid entry seq %0h expected none at %0t", evt_seq, $time);
        end else begin
          if ({evt_rw_n, evt_addr, evt_data, evt_seq} !== exp_q[0]) begin
            fails++;
            $display("FAIL head: got %0h expected %0h at %0t",
                     {evt_rw_n, evt_addr, evt_data, evt_seq}, exp_q[0], $time);
          end
          if (ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic bus(input logic [15:0] a, input logic [7:0] d, input logic r);
    addr = a; data = d; rw_n = r; strobe = 1'b1;
    step();
    strobe = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic drain(output logic [7:0] last_seq);
    int guard;
    guard = 0;
    last_seq = 8'h00;
    ready = 1'b1;
    while (evt_valid && guard < 400) begin
      last_seq = evt_seq;
      step();
      guard++;
    end
    ready = 1'b0;
    check("drain_bound", 64'(guard < 400), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] last;
    logic [15:0] bnd [4];
    bnd[0] = 16'hBFFF; bnd[1] = 16'hC000; bnd[2] = 16'hC0FF; bnd[3] = 16'hC100;

    step();
    step();
    mon_en = 1'b1;
    check("reset_valid", 64'(evt_valid), 64'd0);
    check("reset_count", 64'(count), 64'd0);
    rst = 1'b0;
    step();

    // Single write hit and its latency
    bus(16'hC030, 8'h5A, 1'b0);
    check("lat_t1_valid", 64'(evt_valid), 64'd0);
    step();
    check("lat_t2_valid", 64'(evt_valid), 64'd1);
    check("single_head", 64'({evt_addr, evt_data, evt_rw_n, evt_seq}),
          64'({16'hC030, 8'h5A, 1'b0, 8'h00}));
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("single_pop_valid", 64'(evt_valid), 64'd0);
    check("single_pop_count", 64'(count), 64'd0);

    // Window boundaries, plus a read the writes-only variant must ignore
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus(bnd[i], 8'(i), 1'b0);
    end
    idle(2);
    check("filter_count", 64'(count), 64'd2);
    check("filter_head", 64'({evt_addr, evt_seq}), 64'({16'hC000, 8'h00}));
    bus(16'hC010, 8'h11, 1'b1);
    idle(2);
    check("wo_read_ignored", 64'(wo_count), 64'd2);
    check("filter_read_queued", 64'(count), 64'd3);
    drain(last);

    // Fill and overflow with consumer stalled
    do_reset();
    for (int i = 0; i < 18; i++) bus(16'hC000 + 16'(i), 8'(i), 1'b0);
    idle(2);
    check("fill_count", 64'(count), 64'd16);
    check("fill_drop", 64'(drop_count), 64'd2);
    check("fill_ovf", 64'(overflow), 64'd1);
    check("fill_head_seq", 64'(evt_seq), 64'h00);
    ready = 1'b1;
    step();
    ready = 1'b0;
    bus(16'hC0AA, 8'hEE, 1'b1);
    idle(2);
    drain(last);
    check("next_seq_after_drops", 64'(last), 64'h12);

    // Full FIFO: push and pop land in the same cycle
    do_reset();
    for (int i = 0; i < 16; i++) bus(16'hC020, 8'(i), 1'b0);
    idle(2);
    check("full_count", 64'(count), 64'd16);
    bus(16'hC050, 8'hAA, 1'b0);
    ready = 1'b1;
    step();
    ready = 1'b0;
    check("full_pushpop_count", 64'(count), 64'd16);
    check("full_pushpop_drop", 64'(drop_count), 64'd0);
    drain(last);
    check("full_pushpop_tail", 64'(last), 64'h10);

    // Clear coincident with a hit
    do_reset();
    for (int i = 0; i < 5; i++) bus(16'hC040, 8'(i), 1'b0);
    idle(2);
    addr = 16'hC060; data = 8'h77; rw_n = 1'b0; strobe = 1'b1; clr = 1'b1;
    step();
    strobe = 1'b0; clr = 1'b0;
    idle(2);
    check("clear_count", 64'(count), 64'd0);
    check("clear_valid", 64'(evt_valid), 64'd0);
    bus(16'hC061, 8'h78, 1'b0);
    step();
    check("clear_next_seq", 64'(evt_seq), 64'h05);
    drain(last);

    // Drop counter saturation, then sequence wrap while draining
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 0; i < 300; i++) bus(16'hC000 + 16'(i % 256), 8'(i), 1'(i % 2));
    idle(2);
    check("sat_drop", 64'(drop_count), 64'd255);
    check("sat_ovf", 64'(overflow), 64'd1);
    drain(last);
    ready = 1'b1;
    for (int i = 0; i < 256; i++) bus(16'hC0FF - 16'(i % 256), 8'(i * 3), 1'b0);
    idle(3);
    ready = 1'b0;
    check("wrap_empty", 64'(count), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      strobe = ($urandom_range(2) == 0);
      en     = ($urandom_range(9) != 0);
      ready  = ($urandom_range(4) < 3) ? (c % 400 > 150) : ($urandom_range(1) == 1);
      clr    = ($urandom_range(199) == 0);
      rw_n   = $urandom_range(1);
      data   = 8'($urandom);
      case ($urandom_range(3))
        0: addr = 16'hC000 + 16'($urandom_range(255));
        1: addr = bnd[$urandom_range(3)];
        2: addr = 16'($urandom);
        default: addr = 16'hC000 + 16'($urandom_range(16));
      endcase
      step();
    end
    strobe = 1'b0; en = 1'b1; clr = 1'b0; ready = 1'b0;

    // Reset mid-stream
    for (int i = 0; i < 6; i++) bus(16'hC033, 8'(i), 1'b0);
    addr = 16'hC034; strobe = 1'b1; rst = 1'b1;
    step();
    strobe = 1'b0;
    check("midrst_valid", 64'(evt_valid), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    check("midrst_drop", 64'(drop_count), 64'd0);
    check("midrst_ovf", 64'(overflow), 64'd0);
    rst = 1'b0;
    idle(2);
    check("midrst_no_inflight", 64'(evt_valid), 64'd0);
    bus(16'hC035, 8'h01, 1'b0);
    step();
    check("midrst_seq_restart", 64'(evt_seq), 64'h00);
    drain(last);
    idle(2);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
